fm_wm_port_arbiter: RTL
=======================

Name: fm_wm_port_arbiter

Overview:
- Owns the single-port FM_WM result memory and shares it between two requesters:
  - the transformation writer, which produces FM×WM rows;
  - the combination/adjacency reader, which fetches FM_WM rows per COO entry.
- Round-robin arbitration, with a per-row written scoreboard so a read never returns a row before it has been produced.
- Phase sequencing: IDLE → RUN → DRAIN, ending with a done pulse to the layer controller.

Parameters:
- FM_WM_ROWS, 6, number of rows in the FM_WM memory.
- FM_WM_COLS, 3, elements per row.
- WEIGHT_WIDTH, 16, bits per element.
- ADDR_BW, $clog2(FM_WM_ROWS), row address width.
- ROW_W, FM_WM_COLS*WEIGHT_WIDTH, row data width (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin phase; sampled only in IDLE.
- phase_end  in  1  no further requests will arrive; sampled only in RUN.
- wr_req  in  1  write request; held with addr/data stable until wr_gnt.
- wr_addr  in  ADDR_BW  write row address.
- wr_data  in  ROW_W  write row data.
- wr_gnt  out  1  write accepted this cycle.
- rd_req  in  1  read request; held with addr stable until rd_gnt.
- rd_addr  in  ADDR_BW  read row address.
- rd_gnt  out  1  read accepted this cycle.
- rd_valid  out  1  rd_data valid; one cycle after rd_gnt.
- rd_data  out  ROW_W  read row data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_BW  memory address.
- mem_wdata  out  ROW_W  memory write data.
- mem_rdata  in  ROW_W  memory read data; synchronous read, 1-cycle latency.
- all_written  out  1  every row's scoreboard bit is set.
- addr_err  out  1  sticky out-of-range access flag.
- phase_done  out  1  one-cycle pulse at the end of DRAIN.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; scoreboard all 0; rr_pri = write.
  - All outputs 0; rd_data = 0.
- FSM:
  - IDLE: no grants. If start, clear scoreboard and addr_err, then go to RUN.
  - RUN: arbitrate every cycle. If phase_end, go to DRAIN; any grant issued in that same cycle still completes.
  - DRAIN: no new grants. Wait until no read is outstanding (rd_valid pending = 0), assert phase_done for one cycle, then go to IDLE.
- Eligibility in RUN:
  - W eligible = wr_req.
  - R eligible = rd_req && (addr out of range || written[rd_addr]).
- Arbitration:
  - At most one grant per cycle. If only one requester is eligible, grant it.
  - If both are eligible, grant the side indicated by rr_pri. After any grant, rr_pri points to the other side.
- Grant timing:
  - Grants are combinational in the same cycle as eligibility.
  - mem_en/mem_we/mem_addr/mem_wdata are driven in the grant cycle.
- Write grant, in range:
  - mem_en = 1, mem_we = 1.
  - written[wr_addr] is set at the clock edge ending the grant cycle, so a read of that row is eligible from the next cycle.
- Read grant, in range:
  - mem_en = 1, mem_we = 0.
  - Next cycle: rd_valid = 1 and rd_data = mem_rdata (registered valid, data passed through).
- Out-of-range address (≥ FM_WM_ROWS):
  - Granted immediately with no memory access (mem_en = 0); addr_err is set (sticky until start).
  - For reads, rd_valid still pulses next cycle with rd_data = 0.
- Simultaneous write and read of the same unwritten row: only the write is eligible. The read becomes eligible the next cycle.
- Rewriting an already-written row is allowed; its scoreboard bit stays set.
- all_written = AND of the scoreboard bits; combinational from registered bits.
- Unwritten row: a read request to it stalls indefinitely in RUN. phase_end still moves the FSM to DRAIN; the pending request is dropped and never granted.
- Reset mid-operation: immediate return to IDLE; any pending rd_valid is cancelled; scoreboard cleared.

Decomposition:
- Shared package (gcn_pkg):
  - arb_state_t enum {IDLE, RUN, DRAIN};
  - a requester-id enum {REQ_WR, REQ_RD} for rr_pri.
  - The FM_WM_ROWS/FM_WM_COLS/WEIGHT_WIDTH defaults also live in this package as localparams shared with the combination blocks.
- One sub-module: fm_wm_scoreboard.
  - Holds the written bit-vector with set/clear ports.
  - Outputs: per-address lookup and all_written.

Test Plan:
- Basic write: reset, start, write rows 0..5 with data 0x0001_0002_0003 + row, one per cycle, no reads → wr_gnt every cycle, all_written rises the cycle after the row-5 grant.
- Read hazard: rd_req addr 2 from cycle 0, write addr 2 granted at cycle 3 → rd_gnt at cycle 4, rd_valid at cycle 5 with the written data.
- Contention: wr_req and an eligible rd_req both held for 4 cycles → grants alternate W,R,W,R starting with W after reset.
- Out of range: rd_addr = 7 → granted, mem_en = 0, rd_valid next cycle with rd_data = 0, addr_err = 1 until the next start.
- Drain: phase_end asserted in the same cycle as a read grant → DRAIN, rd_valid next cycle, phase_done pulses one cycle after that, state IDLE, further requests not granted.
- Async reset in RUN with a read outstanding → rd_valid never asserts, all_written = 0, state IDLE.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared definitions for the GCN combination/transformation blocks.
//   - Default FM_WM memory geometry (rows, columns, element width).
//   - arb_state_t : phase FSM states of the FM_WM port arbiter.
//   - req_id_t    : requester identity, used for the round-robin pointer.
package gcn_pkg;

  localparam int DEF_FM_WM_ROWS   = 6;
  localparam int DEF_FM_WM_COLS   = 3;
  localparam int DEF_WEIGHT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } req_id_t;

endpackage

// File: rtl/fm_wm_scoreboard.sv
// Per-row "written" scoreboard for the FM_WM memory.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   clr              clear every bit (start of a phase)
//   set_en, set_addr mark one row as written (ignored if out of range)
//   lookup_addr      row to query
//   lookup_hit       written bit of lookup_addr (0 when out of range)
//   all_written      every row has been written
module fm_wm_scoreboard
  import gcn_pkg::*;
#(
  parameter int ROWS    = DEF_FM_WM_ROWS,
  parameter int ADDR_BW = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               set_en,
  input  logic [ADDR_BW-1:0] set_addr,
  input  logic [ADDR_BW-1:0] lookup_addr,
  output logic               lookup_hit,
  output logic               all_written
);

  logic [ROWS-1:0] written_q;
  logic [ROWS-1:0] written_d;

  // Clear wins over set; the two never coincide in practice (clear only in
  // IDLE, set only in RUN).
  always_comb begin
    written_d = written_q;
    if (clr) begin
      written_d = '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (set_en && (set_addr == ADDR_BW'(i))) begin
          written_d[i] = 1'b1;
        end
      end
    end
  end

  // Address compare instead of a direct index keeps out-of-range lookups
  // from selecting past the end of the vector.
  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (lookup_addr == ADDR_BW'(i)) begin
        lookup_hit = written_q[i];
      end
    end
  end

  assign all_written = &written_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_q <= '0;
    end else begin
      written_q <= written_d;
    end
  end

endmodule

// File: rtl/fm_wm_port_arbiter.sv
// Owner of the single-port FM_WM result memory.
// Shares the memory between the transformation writer (wr_*) and the
// combination/adjacency reader (rd_*) with round-robin arbitration. A read
// is only eligible once its row has been written in the current phase.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, phase_end      phase control (IDLE->RUN, RUN->DRAIN)
//   wr_req/addr/data/gnt  writer handshake (held until granted)
//   rd_req/addr/gnt       reader handshake (held until granted)
//   rd_valid, rd_data     read return, one cycle after rd_gnt
//   mem_*                 single-port synchronous memory interface
//   all_written           every row written this phase
//   addr_err              sticky out-of-range access flag (cleared by start)
//   phase_done            one-cycle pulse when DRAIN completes
module fm_wm_port_arbiter
  import gcn_pkg::*;
#(
  parameter int  FM_WM_ROWS   = DEF_FM_WM_ROWS,
  parameter int  FM_WM_COLS   = DEF_FM_WM_COLS,
  parameter int  WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int  ADDR_BW      = $clog2(FM_WM_ROWS),
  localparam int ROW_W        = FM_WM_COLS * WEIGHT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               phase_end,
  input  logic               wr_req,
  input  logic [ADDR_BW-1:0] wr_addr,
  input  logic [ROW_W-1:0]   wr_data,
  output logic               wr_gnt,
  input  logic               rd_req,
  input  logic [ADDR_BW-1:0] rd_addr,
  output logic               rd_gnt,
  output logic               rd_valid,
  output logic [ROW_W-1:0]   rd_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_BW-1:0] mem_addr,
  output logic [ROW_W-1:0]   mem_wdata,
  input  logic [ROW_W-1:0]   mem_rdata,
  output logic               all_written,
  output logic               addr_err,
  output logic               phase_done
);

  localparam logic [ADDR_BW:0] ROWS_EXT = (ADDR_BW + 1)'(FM_WM_ROWS);

  arb_state_t state_q,    state_d;
  req_id_t    rr_pri_q,   rr_pri_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_oor_q,   rd_oor_d;   // returning read was out of range
  logic       addr_err_q, addr_err_d;

  logic wr_oor, rd_oor;
  logic wr_elig, rd_elig;
  logic rd_row_written;
  logic sb_clr, sb_set;

  assign wr_oor = {1'b0, wr_addr} >= ROWS_EXT;
  assign rd_oor = {1'b0, rd_addr} >= ROWS_EXT;

  fm_wm_scoreboard #(
    .ROWS    (FM_WM_ROWS),
    .ADDR_BW (ADDR_BW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (reset),
    .clr         (sb_clr),
    .set_en      (sb_set),
    .set_addr    (wr_addr),
    .lookup_addr (rd_addr),
    .lookup_hit  (rd_row_written),
    .all_written (all_written)
  );

  // Out-of-range reads bypass the scoreboard: they never touch memory, so
  // there is nothing to wait for.
  always_comb begin
    wr_elig = (state_q == RUN) && wr_req;
    rd_elig = (state_q == RUN) && rd_req && (rd_oor || rd_row_written);
    wr_gnt  = wr_elig && (!rd_elig || (rr_pri_q == REQ_WR));
    rd_gnt  = rd_elig && (!wr_elig || (rr_pri_q == REQ_RD));
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_gnt && !wr_oor) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (rd_gnt && !rd_oor) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end
  end

  assign sb_set = wr_gnt && !wr_oor;

  always_comb begin
    state_d    = state_q;
    rr_pri_d   = rr_pri_q;
    addr_err_d = addr_err_q;
    sb_clr     = 1'b0;
    rd_valid_d = rd_gnt;
    rd_oor_d   = rd_gnt && rd_oor;
    phase_done = 1'b0;

    if (wr_gnt) begin
      rr_pri_d = REQ_RD;
    end else if (rd_gnt) begin
      rr_pri_d = REQ_WR;
    end

    if ((wr_gnt && wr_oor) || (rd_gnt && rd_oor)) begin
      addr_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sb_clr     = 1'b1;
          addr_err_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // A grant issued alongside phase_end still completes normally.
        if (phase_end) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_valid_q) begin
          phase_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_pri_q   <= REQ_WR;
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_pri_q   <= rr_pri_d;
      rd_valid_q <= rd_valid_d;
      rd_oor_q   <= rd_oor_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = (rd_valid_q && !rd_oor_q) ? mem_rdata : '0;
  assign addr_err = addr_err_q;

endmodule
